// File: rtl/uart_rx_if.sv
// Serial-line and received-byte bundle for uart_rx.
// The parity_err strobe exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (input rx, output data, valid, busy, frame_err, parity_err);
  modport slave  (output rx, input data, valid, busy, frame_err, parity_err);
`else
  modport master (input rx, output data, valid, busy, frame_err);
  modport slave  (output rx, input data, valid, busy, frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-cycle valid/frame_err strobes.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic [7:0]       data_q, data_n;
  logic             valid_q, valid_n;
  logic             ferr_q, ferr_n;
  logic             rx_p0, rx_p1;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_n;
  logic             perr_q, perr_n;

  // Even parity: the data bits together with the parity bit XOR to zero.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  // Stage p0/p1: two-flop synchronizer for the asynchronous line, idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_n;
      perr_q  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          idx_n = idx + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (idx == 4'd8) par_n = rx_s;
          else             sh_n  = {rx_s, sh[7:1]};
`else
          sh_n = {rx_s, sh[7:1]};
`endif
          if (idx == LAST_IDX) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_ok(sh, par_q)) begin
              data_n  = sh;
              valid_n = 1'b1;
            end else begin
              perr_n = 1'b1;
            end
`else
            data_n  = sh;
            valid_n = 1'b1;
`endif
          end else begin
            // A low stop bit may be a break; hold off until the line idles.
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences, random frames.
// Honours UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT       = (19 * CPB) / 2 + 3 + PB * CPB;
  localparam int FRAME_CYC = (10 + PB) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;  // 0 valid, 1 frame_err, 2 parity_err
    logic [7:0] d;
    int         cyc;
  } ev_t;

  ev_t ev_q[$];
  int  viol = 0;
  bit  prev_v = 0, prev_f = 0, prev_p = 0;

  always @(negedge clk) begin
    ev_t e;
    bit  p;
    p = 1'b0;
`ifdef UART_RX_PARITY_EN
    p = bus.parity_err;
`endif
    if (!rst) begin
      e.d   = bus.data;
      e.cyc = cyc;
      if (bus.valid)     begin e.kind = 0; ev_q.push_back(e); end
      if (bus.frame_err) begin e.kind = 1; ev_q.push_back(e); end
      if (p)             begin e.kind = 2; ev_q.push_back(e); end
      if ((int'(bus.valid) + int'(bus.frame_err) + int'(p)) > 1) viol++;
      if ((bus.valid && prev_v) || (bus.frame_err && prev_f) || (p && prev_p)) viol++;
    end
    prev_v = bus.valid;
    prev_f = bus.frame_err;
    prev_p = p;
  end

  int checks = 0;
  int failures = 0;
  bit busy_mid;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_kind(input int base, input int kind);
    int n = 0;
    for (int i = base; i < ev_q.size(); i++) if (ev_q[i].kind == kind) n++;
    return n;
  endfunction

  // Drives one frame; stop level is held for stop_hold cycles before idling high.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit pflip,
                            input int stop_hold, output int t0);
    t0 = cyc;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB / 2);
      if (i == 4) busy_mid = bus.busy;
      tick(CPB - CPB / 2);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = (^b) ^ pflip;
    tick(CPB);
`endif
    bus.rx = stop;
    tick(stop_hold);
    bus.rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, t1, base, nev, pf;
    logic [7:0] last_good;
    ev_t exp_q[$];
    ev_t m;

    vecs[0] = '{8'hAA, 1'b1, 1, 0, 8'hAA};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h0F, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    bus.rx = 1'b1;
    rst = 1'b1;
    tick(3);
    check("reset_data", bus.data, 8'h00);
    check("reset_valid", bus.valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_ferr", bus.frame_err, 0);
`ifdef UART_RX_PARITY_EN
    check("reset_perr", bus.parity_err, 0);
`endif
    rst = 1'b0;
    tick(4);

    foreach (vecs[k]) begin
      base = ev_q.size();
      send_frame(vecs[k].b, vecs[k].stop_ok, 1'b0, CPB, t0);
      tick(2 * CPB);
      check($sformatf("vec%0d_valid", k), count_kind(base, 0), vecs[k].exp_valid);
      check($sformatf("vec%0d_ferr", k), count_kind(base, 1), vecs[k].exp_ferr);
      check($sformatf("vec%0d_data", k), bus.data, vecs[k].exp_data);
      check($sformatf("vec%0d_busy_mid", k), busy_mid, 1);
      if (ev_q.size() > base)
        check_range($sformatf("vec%0d_latency", k), ev_q[base].cyc - t0, LAT - 1, LAT + 1);
    end

    // Back-to-back frames, no idle between stop bit and next start bit.
    base = ev_q.size();
    send_frame(8'h5A, 1'b1, 1'b0, CPB, t0);
    send_frame(8'h3C, 1'b1, 1'b0, CPB, t1);
    tick(2 * CPB);
    nev = ev_q.size() - base;
    check("b2b_count", count_kind(base, 0), 2);
    if (nev >= 2) begin
      check("b2b_data0", ev_q[base].d, 8'h5A);
      check("b2b_data1", ev_q[base + 1].d, 8'h3C);
      check_range("b2b_spacing", ev_q[base + 1].cyc - ev_q[base].cyc, FRAME_CYC - 1, FRAME_CYC + 1);
    end

    // Two-cycle glitch: a false start must leave no trace.
    base = ev_q.size();
    t0 = cyc;
    bus.rx = 1'b0;
    tick(2);
    bus.rx = 1'b1;
    tick(2);
    check("glitch_busy_rise", bus.busy, 1);
    tick(8);
    check("glitch_busy_fall", bus.busy, 0);
    check("glitch_events", ev_q.size() - base, 0);
    check("glitch_data", bus.data, 8'h3C);

    // Break: stop low and line held low 40 more cycles.
    base = ev_q.size();
    send_frame(8'h0F, 1'b0, 1'b0, CPB + 40, t0);
    check("break_busy_low_line", bus.busy, 1);
    tick(6);
    check("break_busy_release", bus.busy, 0);
    tick(2 * CPB);
    check("break_ferr", count_kind(base, 1), 1);
    check("break_events", ev_q.size() - base, 1);
    check("break_data", bus.data, 8'h3C);

    // Reset during bit 4 of 0xFF.
    base = ev_q.size();
    bus.rx = 1'b0;
    tick(CPB);
    bus.rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    rst = 1'b1;
    tick(2);
    check("midrst_data", bus.data, 8'h00);
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.valid, 0);
    check("midrst_ferr", bus.frame_err, 0);
    rst = 1'b0;
    tick(12 * CPB);
    check("midrst_no_strobe", ev_q.size() - base, 0);
    send_frame(8'h81, 1'b1, 1'b0, CPB, t0);
    tick(2 * CPB);
    check("postrst_valid", count_kind(base, 0), 1);
    check("postrst_data", bus.data, 8'h81);

`ifdef UART_RX_PARITY_EN
    base = ev_q.size();
    send_frame(8'h07, 1'b1, 1'b0, CPB, t0);
    tick(2 * CPB);
    check("par_good_valid", count_kind(base, 0), 1);
    check("par_good_data", bus.data, 8'h07);
    base = ev_q.size();
    send_frame(8'h07, 1'b1, 1'b1, CPB, t0);
    tick(2 * CPB);
    check("par_bad_perr", count_kind(base, 2), 1);
    check("par_bad_valid", count_kind(base, 0), 0);
    check("par_bad_data", bus.data, 8'h07);
`endif

    // Random frames against a frame-level model of expected strobes.
    base = ev_q.size();
    last_good = bus.data;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      pf  = (PB != 0) ? int'($urandom_range(0, 5) == 0) : 0;
      m.d = b;
      m.cyc = 0;
      if (bad)          m.kind = 1;
      else if (pf != 0) m.kind = 2;
      else begin        m.kind = 0; last_good = b; end
      exp_q.push_back(m);
      send_frame(b, !bad, pf[0], CPB, t0);
      tick(bad ? CPB : int'($urandom_range(0, 3)));
    end
    tick(3 * CPB);
    check("rand_count", ev_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < ev_q.size(); i++) begin
      check($sformatf("rand%0d_kind", i), ev_q[base + i].kind, exp_q[i].kind);
      if (exp_q[i].kind == 0)
        check($sformatf("rand%0d_data", i), ev_q[base + i].d, exp_q[i].d);
    end
    check("rand_final_data", bus.data, last_good);
    check("strobe_protocol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
